// File: rtl/seq_det_pkg.sv
// Shared definitions for the sequence-detector datapath: serializer FSM
// encoding, default word width and the pattern the downstream detector matches.
package seq_det_pkg;

    // Serializer state encoding
    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } ser_state_t;

    // Default parallel word width
    localparam int DEFAULT_WIDTH = 8;

    // Pattern recognised by the Moore detector fed by the serializer
    localparam logic [3:0] DET_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the Moore sequence detector. Words arrive on a
// valid/ready handshake and leave one bit per clock. A one-word holding
// register lets consecutive words stream without an idle gap. Idle cycles are
// filled with IDLE_BIT. All serial outputs are decoded from flops only.
module seq_bit_serializer
    import seq_det_pkg::*;
#(
    parameter int   WIDTH     = DEFAULT_WIDTH,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    ser_state_t       state_reg, state_next;
    logic [WIDTH-1:0] shifter_reg, shifter_next;
    logic [WIDTH-1:0] hold_reg, hold_next;
    logic             hold_full_reg, hold_full_next;
    logic [CW-1:0]    cnt_reg, cnt_next;

    logic             take;
    logic             last_bit;
    logic [WIDTH-1:0] shifter_adv;

    // Ready only when the holding register is free; held low through reset so
    // nothing is captured while rst is asserted.
    assign in_ready = !hold_full_reg && !rst;
    assign take     = in_valid && in_ready;
    assign last_bit = (cnt_reg == LAST_CNT);

    // Shifter advanced by one bit toward the emitted end, zero filled
    assign shifter_adv = (MSB_FIRST != 0) ? {shifter_reg[WIDTH-2:0], 1'b0}
                                          : {1'b0, shifter_reg[WIDTH-1:1]};

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            shifter_reg   <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            shifter_reg   <= shifter_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            cnt_reg       <= cnt_next;
        end
    end

    // Next-state logic: load from input when idle, shift while busy, and on the
    // last bit reload from hold first, then from a fresh transfer, else go idle.
    always_comb begin
        state_next     = state_reg;
        shifter_next   = shifter_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        cnt_next       = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (take) begin
                    shifter_next = in_data;
                    cnt_next     = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (!last_bit) begin
                    shifter_next = shifter_adv;
                    cnt_next     = cnt_reg + CW'(1);
                    if (take) begin
                        hold_next      = in_data;
                        hold_full_next = 1'b1;
                    end
                end else if (hold_full_reg) begin
                    shifter_next   = hold_reg;
                    hold_full_next = 1'b0;
                    cnt_next       = '0;
                end else if (take) begin
                    shifter_next = in_data;
                    cnt_next     = '0;
                end else begin
                    shifter_next = shifter_adv;
                    cnt_next     = '0;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Serial outputs decoded purely from registered state
    assign ser_valid = (state_reg == SHIFT);
    assign ser_out   = ser_valid ? ((MSB_FIRST != 0) ? shifter_reg[WIDTH-1] : shifter_reg[0])
                                 : IDLE_BIT;
    assign word_done = ser_valid && last_bit;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Bench for seq_bit_serializer: one MSB-first instance with idle fill 0 and one
// LSB-first instance with idle fill 1. Accepted words push their expected bits
// to a per-instance queue; a monitor pops and compares every serial cycle.
module tb_seq_bit_serializer;
    import seq_det_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] in_data0, in_data1;
    logic       in_valid0, in_valid1;
    logic       in_ready0, in_ready1;
    logic       ser_out0, ser_out1;
    logic       ser_valid0, ser_valid1;
    logic       word_done0, word_done1;

    int n_pass   = 0;
    int n_checks = 0;

    // expected {word_done, ser_out} per valid serial cycle
    logic [1:0] exp0[$];
    logic [1:0] exp1[$];
    logic [1:0] e0, e1;

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0),
        .in_ready(in_ready0), .ser_out(ser_out0), .ser_valid(ser_valid0),
        .word_done(word_done0)
    );

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1),
        .in_ready(in_ready1), .ser_out(ser_out1), .ser_valid(ser_valid1),
        .word_done(word_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: outputs sampled on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (ser_valid0) begin
                if (exp0.size() == 0) begin
                    $display("FAIL mon0_unexpected: got ser_out=%0b word_done=%0b, required no valid bit", ser_out0, word_done0);
                end else begin
                    e0 = exp0.pop_front();
                    if ({word_done0, ser_out0} !== e0)
                        $display("FAIL mon0_bit: got done,bit=%b required %b", {word_done0, ser_out0}, e0);
                    else n_pass++;
                end
            end else if ({word_done0, ser_out0} !== 2'b00) begin
                $display("FAIL mon0_idle: got done,bit=%b required 00", {word_done0, ser_out0});
            end else n_pass++;

            n_checks++;
            if (ser_valid1) begin
                if (exp1.size() == 0) begin
                    $display("FAIL mon1_unexpected: got ser_out=%0b word_done=%0b, required no valid bit", ser_out1, word_done1);
                end else begin
                    e1 = exp1.pop_front();
                    if ({word_done1, ser_out1} !== e1)
                        $display("FAIL mon1_bit: got done,bit=%b required %b", {word_done1, ser_out1}, e1);
                    else n_pass++;
                end
            end else if ({word_done1, ser_out1} !== 2'b01) begin
                $display("FAIL mon1_idle: got done,bit=%b required 01", {word_done1, ser_out1});
            end else n_pass++;
        end
    end

    // Present one word for one cycle on instance 0 (called just after a falling edge)
    task automatic drive0(input logic v, input logic [7:0] d, output logic acc);
        in_valid0 = v;
        in_data0  = d;
        #1;
        acc = v && in_ready0;
        if (acc) for (int i = 7; i >= 0; i--) exp0.push_back({(i == 0), d[i]});
        @(posedge clk);
        #1 in_valid0 = 1'b0;
        @(negedge clk);
        $display("txn dut0 valid=%0b data=%02h accepted=%0b", v, d, acc);
    endtask

    task automatic drive1(input logic v, input logic [7:0] d, output logic acc);
        in_valid1 = v;
        in_data1  = d;
        #1;
        acc = v && in_ready1;
        if (acc) for (int i = 0; i < 8; i++) exp1.push_back({(i == 7), d[i]});
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        @(negedge clk);
        $display("txn dut1 valid=%0b data=%02h accepted=%0b", v, d, acc);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++; if ({ser_valid0, ser_out0, word_done0} !== 3'b000) $display("FAIL rst_out0: got %b required 000", {ser_valid0, ser_out0, word_done0}); else n_pass++;
        n_checks++; if ({ser_valid1, ser_out1, word_done1} !== 3'b010) $display("FAIL rst_out1: got %b required 010", {ser_valid1, ser_out1, word_done1}); else n_pass++;
        n_checks++; if ({in_ready0, in_ready1} !== 2'b00) $display("FAIL rst_ready: got %b required 00", {in_ready0, in_ready1}); else n_pass++;
        #1 rst = 1'b0;
        #1;
        n_checks++; if ({in_ready0, in_ready1} !== 2'b11) $display("FAIL rst_release_ready: got %b required 11", {in_ready0, in_ready1}); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic acc;
        logic [3:0] hist;
        int nvalid, hits;
        hist = 4'b0000; nvalid = 0; hits = 0;
        drive0(1'b1, 8'hB0, acc);
        n_checks++; if (acc !== 1'b1) $display("FAIL single_accept: got %0b required 1", acc); else n_pass++;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (ser_valid0) begin
                nvalid++;
                hist = {hist[2:0], ser_out0};
                if (hist == DET_PATTERN) hits++;
            end
            n_checks++; if (ser_valid0 !== (cyc <= 8)) $display("FAIL single_valid c%0d: got %0b required %0b", cyc, ser_valid0, (cyc <= 8)); else n_pass++;
            n_checks++; if (word_done0 !== (cyc == 8)) $display("FAIL single_done c%0d: got %0b required %0b", cyc, word_done0, (cyc == 8)); else n_pass++;
            @(negedge clk);
        end
        n_checks++; if (nvalid != 8) $display("FAIL single_count: got %0d required 8", nvalid); else n_pass++;
        n_checks++; if (hits != 1) $display("FAIL single_detect: got %0d required 1", hits); else n_pass++;
        n_checks++; if (exp0.size() != 0) $display("FAIL single_drain: got %0d pending required 0", exp0.size()); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic acc, acc2;
        drive0(1'b1, 8'hB0, acc);
        n_checks++; if (acc !== 1'b1) $display("FAIL b2b_accept1: got %0b required 1", acc); else n_pass++;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            n_checks++; if (in_ready0 !== (cyc == 1 || cyc >= 9)) $display("FAIL b2b_ready c%0d: got %0b required %0b", cyc, in_ready0, (cyc == 1 || cyc >= 9)); else n_pass++;
            n_checks++; if (ser_valid0 !== (cyc <= 16)) $display("FAIL b2b_valid c%0d: got %0b required %0b", cyc, ser_valid0, (cyc <= 16)); else n_pass++;
            if (cyc == 1) begin
                drive0(1'b1, 8'h5A, acc2);
                n_checks++; if (acc2 !== 1'b1) $display("FAIL b2b_accept2: got %0b required 1", acc2); else n_pass++;
            end else begin
                @(negedge clk);
            end
        end
        n_checks++; if (exp0.size() != 0) $display("FAIL b2b_drain: got %0d pending required 0", exp0.size()); else n_pass++;
    endtask

    task automatic test_lsb_first;
        logic acc;
        drive1(1'b1, 8'h0D, acc);
        n_checks++; if (acc !== 1'b1) $display("FAIL lsb_accept: got %0b required 1", acc); else n_pass++;
        n_checks++; if ({ser_valid1, ser_out1} !== 2'b11) $display("FAIL lsb_first_bit: got %b required 11", {ser_valid1, ser_out1}); else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++; if (exp1.size() != 0) $display("FAIL lsb_drain: got %0d pending required 0", exp1.size()); else n_pass++;
    endtask

    task automatic test_idle_fill;
        for (int cyc = 0; cyc < 20; cyc++) begin
            n_checks++;
            if ({ser_out1, ser_valid1, in_ready1} !== 3'b101)
                $display("FAIL idle_fill c%0d: got out,valid,ready=%b required 101", cyc, {ser_out1, ser_valid1, in_ready1});
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_word;
        logic acc, acc2;
        drive0(1'b1, 8'hFF, acc);
        drive0(1'b1, 8'hAA, acc2);
        n_checks++; if ({acc, acc2} !== 2'b11) $display("FAIL rmw_accept: got %b required 11", {acc, acc2}); else n_pass++;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({ser_valid0, ser_out0, word_done0, in_ready0} !== 4'b0000) $display("FAIL rmw_async: got %b required 0000", {ser_valid0, ser_out0, word_done0, in_ready0}); else n_pass++;
        exp0.delete();
        in_valid0 = 1'b1;
        in_data0  = 8'h33;
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready0 !== 1'b0) $display("FAIL rmw_ready_in_rst: got %0b required 0", in_ready0); else n_pass++;
        in_valid0 = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        for (int cyc = 0; cyc < 12; cyc++) begin
            n_checks++; if (ser_valid0 !== 1'b0) $display("FAIL rmw_no_replay c%0d: got %0b required 0", cyc, ser_valid0); else n_pass++;
            @(negedge clk);
        end
        drive0(1'b1, 8'h81, acc);
        n_checks++; if (acc !== 1'b1) $display("FAIL rmw_new_accept: got %0b required 1", acc); else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++; if (exp0.size() != 0) $display("FAIL rmw_drain: got %0d pending required 0", exp0.size()); else n_pass++;
    endtask

    task automatic test_last_bit_arrival;
        logic acc, acc2;
        logic found;
        found = 1'b0;
        drive0(1'b1, 8'h3C, acc);
        for (int k = 0; k < 20; k++) begin
            if (word_done0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++; if (found !== 1'b1) $display("FAIL last_done_seen: got %0b required 1", found); else n_pass++;
        drive0(1'b1, 8'hC5, acc2);
        n_checks++; if (acc2 !== 1'b1) $display("FAIL last_accept: got %0b required 1", acc2); else n_pass++;
        n_checks++; if ({ser_valid0, in_ready0} !== 2'b11) $display("FAIL last_no_gap: got valid,ready=%b required 11", {ser_valid0, in_ready0}); else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++; if (exp0.size() != 0) $display("FAIL last_drain: got %0d pending required 0", exp0.size()); else n_pass++;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        in_data0  = '0;
        in_data1  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb_first();
        test_idle_fill();
        test_reset_mid_word();
        test_last_bit_arrival();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream feeder stage for the Moore sequence detector.
- Accepts parallel words over a valid/ready handshake and emits them as a continuous one-bit-per-clock serial stream.
- The stream drives the detector's single-bit input directly.
- A one-word holding register lets back-to-back words stream with no idle gap. When no data is available, a configurable idle bit fills the stream.

Parameters:
- WIDTH, 8: bits per parallel word; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is emitted first; 0 = bit 0 is emitted first.
- IDLE_BIT, 0: value driven on ser_out while no word is being shifted.

Ports:
- clk  input  1  single rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- in_data  input  WIDTH  parallel word from the upstream source.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word this cycle.
- ser_out  output  1  serial bit; connects to the detector's data input.
- ser_valid  output  1  ser_out carries a data bit (not idle fill).
- word_done  output  1  one-cycle pulse while the last bit of a word is on ser_out.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE, hold_full=0, shifter=0, cnt=0.
  - ser_valid=0, ser_out=IDLE_BIT, word_done=0.
  - in_ready is forced to 0 while rst is high, so no word is captured during reset.
- Handshake:
  - A word transfers on a rising edge where in_valid=1 and in_ready=1.
  - in_ready = !hold_full && !rst; it depends only on flops and rst, never on in_valid.
  - in_data must stay stable while in_valid=1 and in_ready=0.
- State machine (2 states), with shifter[WIDTH-1:0] and cnt[$clog2(WIDTH)-1:0]:
  - IDLE: ser_valid=0, ser_out=IDLE_BIT.
    - On transfer: shifter<=in_data, cnt<=0, next=SHIFT.
    - Invariant: hold_full=0 in IDLE.
  - SHIFT: ser_valid=1.
    - ser_out = MSB_FIRST ? shifter[WIDTH-1] : shifter[0].
    - word_done = (cnt==WIDTH-1).
  - SHIFT, cnt<WIDTH-1:
    - shift toward the emitted end (zero fill), cnt<=cnt+1.
    - A transfer this cycle loads hold, hold_full<=1.
  - SHIFT, cnt==WIDTH-1 (last bit), priority order:
    - (a) hold_full: shifter<=hold, hold_full<=0, cnt<=0, stay SHIFT. in_ready was 0, so no transfer is possible.
    - (b) otherwise, transfer this cycle: shifter<=in_data, cnt<=0, stay SHIFT.
    - (c) otherwise: next=IDLE.
- Latency:
  - Word accepted at edge N while IDLE: its first bit appears on ser_out in the cycle after edge N.
  - Exactly WIDTH consecutive ser_valid cycles per word.
- Throughput: continuous streaming gives 1 bit/clk with zero gap between words. in_ready is low for at most WIDTH-1 cycles per word.
- ser_out, ser_valid and word_done are decoded from flops only, with no input-to-output combinational path. The detector sees a glitch-free bit every clock.
- Reset mid-word: the partial word and any held word are discarded, with no partial bit replay. After rst falls, the first transfer starts a fresh word.
- Simultaneous events:
  - Transfer on the last-bit cycle with the hold empty is case (b). It is never lost and never goes to hold.
  - A transfer cannot coincide with case (a).
- Bits are never reordered or duplicated; the word order out equals the transfer order in.

Decomposition:
- Shared package `seq_det_pkg`:
  - FSM state encoding constants (IDLE, SHIFT) as a 1-bit localparam pair.
  - Default WIDTH.
  - Detector pattern constant (4'b1011) for bench reuse.
- No sub-module. The holding register and shifter are small enough to live inline.
- A top-level wrapper instantiating seq_bit_serializer plus the detector is a separate integration file, not part of this block.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1, in_data=8'hB0, one transfer from IDLE:
  - ser_out=1,0,1,1,0,0,0,0 on cycles 1..8, ser_valid=1 on all eight, word_done=1 only on cycle 8.
  - Then ser_out=IDLE_BIT, ser_valid=0.
  - The attached detector asserts out exactly once, the cycle after the fourth bit.
- Back-to-back 8'hB0 then 8'h5A with in_valid held high:
  - 16 contiguous ser_valid cycles; in_ready=0 for cycles 2..8 of word 1.
  - Second word's bits 0,1,0,1,1,0,1,0 follow with no gap.
- LSB_FIRST (MSB_FIRST=0), in_data=8'h0D: emitted order 1,0,1,1,0,0,0,0.
- Idle fill, IDLE_BIT=1, no transfers for 20 cycles: ser_out=1 and ser_valid=0 throughout; in_ready=1.
- Reset mid-word, rst pulsed after 3 bits of 8'hFF while a second word sits in hold:
  - Outputs return to reset values asynchronously and in_ready=0 during rst.
  - After release, no further bits from either word; a new 8'h81 streams 1,0,0,0,0,0,0,1.
- Last-bit arrival: hold empty, transfer presented exactly on the word_done cycle. The new word starts on the next cycle with no gap and hold_full stays 0.
